pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor.
- Successor to the team's single-bit full adder: generalised to WIDTH bits, split into STAGES registered carry-chain slices, with a runtime add/sub mode, signed-overflow flag and valid/ready handshaking.
- Used as the arithmetic datapath slice feeding accumulators and ALU blocks at clock rates where a full-width ripple chain would miss timing.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices; each slice resolves WIDTH/STAGES bits; 1 is legal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add) / borrow-in (sub)
- Sub  input  1  0 = add, 1 = subtract; sampled with operands
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- Sum  output  WIDTH  result
- Cout  output  1  carry-out; in Sub mode 1 = no borrow
- Ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: asynchronous assertion of rst_n=0 clears all stage valid bits, Sum, Cout and Ovf to 0 immediately. in_ready=1 after reset. Data in flight is discarded.
- Arithmetic:
  - Add: {Cout,Sum} = A + B + Cin.
  - Sub: {Cout,Sum} = A + ~B + ~Cin, which equals A - B - Cin.
  - Ovf = carry into the MSB XOR carry out of the MSB.
- Slicing:
  - Slice k adds bits [k*W/S +: W/S] together with the registered carry from slice k-1.
  - Not-yet-processed upper operand bits and the Sub flag travel down the pipe in skew registers.
  - Already-resolved lower sum bits are carried forward in deskew registers, so Sum leaves the last stage fully aligned.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready at edge N) to out_valid=1 with the matching result (visible after edge N+STAGES-1 for STAGES≥1; the first slice registers on acceptance).
- Throughput: one operation per cycle when out_ready=1.
- Handshake:
  - Transfer occurs on any edge where valid && ready.
  - in_ready = !out_valid || out_ready (global stall).
  - When out_valid=1 and out_ready=0, every stage holds its contents, and Sum/Cout/Ovf stay stable.
  - in_valid=1 with in_ready=0 is ignored; the source must hold A, B, Cin and Sub.
- Bubbles: a stage with valid=0 carries no token. Bubbles propagate; they do not compress during a stall. out_valid drops to 0 after the last token drains when no new input arrives.
- Simultaneous accept at input and output on the same edge is legal: the pipe advances by one.
- Sub toggling between back-to-back operations must not corrupt either result, since mode is pipelined per token.
- Ordering: results emerge in acceptance order. No token is lost or duplicated under any out_ready pattern.

Test Plan:
- WIDTH=16, STAGES=4, add 0xFFFF + 0x0001, Cin=0 -> after 4 cycles Sum=0x0000, Cout=1, Ovf=0, out_valid=1 for one cycle.
- Add 0x7FFF + 0x0001, Cin=0 -> Sum=0x8000, Cout=0, Ovf=1. Sub 0x0005 - 0x0007, Cin=0 -> Sum=0xFFFE, Cout=0, Ovf=0.
- Stream 8 consecutive operations alternating Add and Sub with out_ready=1 -> 8 correct results on 8 consecutive cycles starting at cycle 4, in order.
- Stream with out_ready low for 3 cycles mid-burst -> in_ready=0 during the stall; output held stable; no loss or duplication; results match a reference model.
- Assert rst_n=0 mid-stream with 3 tokens in flight -> out_valid and Sum clear immediately; after release in_ready=1 and no stale results appear.
- STAGES=1, WIDTH=8: 0x80 + 0x80, Cin=1 -> next cycle Sum=0x01, Cout=1, Ovf=1. Random 10k operations versus reference model for {WIDTH,STAGES} = {16,4}, {32,8}, {8,1}.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit ripple-carry adder/subtractor split into STAGES registered slices with valid/ready flow control
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0] valid_q, valid_d;
    logic              advance;
    logic              ovf_q, ovf_d;

    // One global enable: the whole pipe moves only when the output slot is free or being drained.
    assign out_valid = valid_q[STAGES-1];
    assign in_ready  = !out_valid || out_ready;
    assign advance   = in_ready;
    assign valid_d   = (valid_q << 1) | STAGES'(in_valid);

    // Token valid bits shift with the data; bubbles keep their place during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else if (advance) valid_q <= valid_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // RW: operand bits not yet consumed when entering slice k; DW: result bits resolved after slice k.
        localparam int RW = WIDTH - k * SW;
        localparam int DW = (k + 1) * SW;

        logic [RW-1:0] a_in, b_in;
        logic          sub_in, c_in;
        logic [SW-1:0] b_eff, s_d;
        logic          c_d;
        logic [DW-1:0] sum_d, sum_q;
        logic          c_q;

        if (k == 0) begin : g_src
            // Slice 0 works straight off the ports; subtract turns the borrow-in into an inverted carry-in.
            assign a_in   = A;
            assign b_in   = B;
            assign sub_in = Sub;
            assign c_in   = Cin ^ Sub;
            assign sum_d  = s_d;
        end else begin : g_src
            logic [RW-1:0] a_q, b_q;
            logic          sub_q;

            // Skew registers: unprocessed upper operand bits and the token's mode follow it down the pipe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (advance) begin
                    a_q   <= g_st[k-1].a_in[RW+SW-1:SW];
                    b_q   <= g_st[k-1].b_in[RW+SW-1:SW];
                    sub_q <= g_st[k-1].sub_in;
                end
            end

            assign a_in   = a_q;
            assign b_in   = b_q;
            assign sub_in = sub_q;
            assign c_in   = g_st[k-1].c_q;
            assign sum_d  = {s_d, g_st[k-1].sum_q};
        end

        assign b_eff      = b_in[SW-1:0] ^ {SW{sub_in}};
        assign {c_d, s_d} = (SW + 1)'(a_in[SW-1:0]) + (SW + 1)'(b_eff) + (SW + 1)'(c_in);

        // Deskew register: resolved low bits plus this slice's bits, and the carry into the next slice.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (advance) begin
                sum_q <= sum_d;
                c_q   <= c_d;
            end
        end
    end

    // Carry into the MSB is recovered as sum ^ a ^ b at that bit, so overflow needs no extra tap in the adder.
    assign ovf_d = g_st[STAGES-1].c_d ^ g_st[STAGES-1].s_d[SW-1]
                 ^ g_st[STAGES-1].a_in[SW-1] ^ g_st[STAGES-1].b_eff[SW-1];

    // Overflow is only known once the top slice resolves, so it is registered alongside the final sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (advance) ovf_q <= ovf_d;
    end

    assign Sum  = g_st[STAGES-1].sum_q;
    assign Cout = g_st[STAGES-1].c_q;
    assign Ovf  = ovf_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed and random checks of three adder/subtractor configurations against an arithmetic model
module tb_pipelined_add_sub;
    localparam int N = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  iv, ordy, irdy, ov, cin, sub, co, of;
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [15:0] s0;
    logic [31:0] s1;
    logic [7:0]  s2;
    logic [31:0] act_sum [3];
    logic [33:0] exp_q [3][$];
    logic [33:0] held [3];
    logic [2:0]  hold_v;
    int          acc_cnt [3];
    int          sent [3];
    int          popped [3];
    int          tgt [3];
    int          base, base_sent;
    int          checks = 0;
    int          errors = 0;

    assign act_sum[0] = {16'h0, s0};
    assign act_sum[1] = s1;
    assign act_sum[2] = {24'h0, s2};

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .A(a[0][15:0]), .B(b[0][15:0]), .Cin(cin[0]), .Sub(sub[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .Sum(s0), .Cout(co[0]), .Ovf(of[0]));

    pipelined_add_sub #(.WIDTH(32), .STAGES(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .A(a[1]), .B(b[1]), .Cin(cin[1]), .Sub(sub[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .Sum(s1), .Cout(co[1]), .Ovf(of[1]));

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .A(a[2][7:0]), .B(b[2][7:0]), .Cin(cin[2]), .Sub(sub[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .Sum(s2), .Cout(co[2]), .Ovf(of[2]));

    function automatic int wof(int i);
        return i == 0 ? 16 : (i == 1 ? 32 : 8);
    endfunction

    // Result as {Ovf, Cout, Sum}: unsigned arithmetic gives Sum/Cout, signed arithmetic gives Ovf.
    function automatic logic [33:0] model(int w, logic [31:0] av, logic [31:0] bv, logic c, logic s);
        longint full = longint'(1) << w;
        longint half = full / 2;
        longint ua   = longint'(av) & (full - 1);
        longint ub   = longint'(bv) & (full - 1);
        longint ci   = longint'(c);
        longint sa   = ua >= half ? ua - full : ua;
        longint sb   = ub >= half ? ub - full : ub;
        longint r    = s ? ua - ub - ci : ua + ub + ci;
        longint sr   = s ? sa - sb - ci : sa + sb + ci;
        logic   cy   = s ? (r >= 0) : (r >= full);
        logic   ovl  = (sr >= half) || (sr < -half);
        return {ovl, cy, 32'(r & (full - 1))};
    endfunction

    task automatic chk(string tag, logic [33:0] got, logic [33:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic send(int i, logic [31:0] av, logic [31:0] bv, logic c, logic s);
        a[i] = av;
        b[i] = bv;
        cin[i] = c;
        sub[i] = s;
        iv[i] = 1'b1;
        sent[i]++;
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
    endtask

    // Offers a new random operation only once the previous offer has been taken; otherwise holds it.
    task automatic drive(int i, bit more, bit alt);
        if (acc_cnt[i] == sent[i]) begin
            iv[i] = more;
            if (more) begin
                a[i] = $urandom;
                b[i] = $urandom;
                cin[i] = 1'($urandom_range(0, 1));
                sub[i] = alt ? 1'(sent[i] % 2) : 1'($urandom_range(0, 1));
                sent[i]++;
            end
        end
    endtask

    task automatic lat_chk(int i, int lat, logic [33:0] want);
        for (int c = 1; c < lat; c++) begin
            chk("lat_early", 34'(ov[i]), 34'(0));
            @(posedge clk);
            #1;
        end
        chk("lat_valid", 34'(ov[i]), 34'(1));
        chk("dir_result", {of[i], co[i], act_sum[i]}, want);
        @(posedge clk);
        #1;
        chk("one_shot", 34'(ov[i]), 34'(0));
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0; c++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), 34'(exp_q[i].size()), 34'(0));
    endtask

    // Output monitor and scoreboard, sampled mid-cycle where every signal is settled.
    always @(negedge clk) begin
        if (!rst_n) hold_v = '0;
        else for (int i = 0; i < 3; i++) begin
            automatic logic [33:0] got = {of[i], co[i], act_sum[i]};
            chk($sformatf("in_ready%0d", i), 34'(irdy[i]), 34'(!ov[i] || ordy[i]));
            if (hold_v[i]) begin
                chk($sformatf("stall_valid%0d", i), 34'(ov[i]), 34'(1));
                chk($sformatf("stall_data%0d", i), got, held[i]);
            end
            if (ov[i] && ordy[i]) begin
                if (exp_q[i].size() == 0) chk($sformatf("spurious%0d", i), 34'(ov[i]), 34'(0));
                else begin
                    chk($sformatf("result%0d", i), got, exp_q[i].pop_front());
                    popped[i]++;
                end
            end
            hold_v[i] = ov[i] && !ordy[i];
            held[i] = got;
            if (iv[i] && irdy[i]) begin
                exp_q[i].push_back(model(wof(i), a[i], b[i], cin[i], sub[i]));
                acc_cnt[i]++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iv = '0;
        ordy = '1;
        cin = '0;
        sub = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            b[i] = '0;
            acc_cnt[i] = 0;
            sent[i] = 0;
            popped[i] = 0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), 34'(ov[i]), 34'(0));
            chk($sformatf("rst_out%0d", i), {of[i], co[i], act_sum[i]}, 34'(0));
            chk($sformatf("rst_ready%0d", i), 34'(irdy[i]), 34'(1));
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
        lat_chk(0, 4, {1'b0, 1'b1, 32'h0000_0000});
        send(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
        lat_chk(0, 4, {1'b1, 1'b0, 32'h0000_8000});
        send(0, 32'h0005, 32'h0007, 1'b0, 1'b1);
        lat_chk(0, 4, {1'b0, 1'b0, 32'h0000_FFFE});
        send(2, 32'h80, 32'h80, 1'b1, 1'b0);
        lat_chk(2, 1, {1'b1, 1'b1, 32'h0000_0001});

        base = popped[0];
        for (int j = 0; j < 12; j++) begin
            drive(0, j < 8, 1'b1);
            @(posedge clk);
            #1;
            chk("stream_valid", 34'(ov[0]), 34'(j >= 3 && j <= 10));
        end
        chk("stream_count", 34'(popped[0] - base), 34'(8));

        base = popped[0];
        base_sent = sent[0];
        for (int j = 0; j < 20; j++) begin
            ordy[0] = !(j >= 6 && j <= 8);
            drive(0, sent[0] < base_sent + 12, 1'b0);
            #1;
            if (j >= 6 && j <= 8) chk("stall_in_ready", 34'(irdy[0]), 34'(0));
            @(posedge clk);
            #1;
        end
        drain();
        chk("stall_count", 34'(popped[0] - base), 34'(12));

        for (int j = 0; j < 4; j++) begin
            drive(0, 1'b1, 1'b0);
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0;
        sent[0] = acc_cnt[0];
        chk("pre_reset_valid", 34'(ov[0]), 34'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 34'(ov[0]), 34'(0));
        chk("mid_rst_out", {of[0], co[0], act_sum[0]}, 34'(0));
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_ready", 34'(irdy[0]), 34'(1));
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("no_stale", 34'(ov[0]), 34'(0));
        end

        for (int i = 0; i < 3; i++) tgt[i] = acc_cnt[i] + N;
        for (int c = 0; c < 40000 && (acc_cnt[0] < tgt[0] || acc_cnt[1] < tgt[1] || acc_cnt[2] < tgt[2]); c++) begin
            for (int i = 0; i < 3; i++) begin
                ordy[i] = $urandom_range(0, 3) != 0;
                drive(i, sent[i] < tgt[i] && $urandom_range(0, 9) < 8, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 1'b0);
            chk($sformatf("random_count%0d", i), 34'(acc_cnt[i]), 34'(tgt[i]));
        end
        ordy = '1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
